// File: rtl/sigma_delta_dac_mc.sv
// Multi-channel sigma-delta DAC: each accepted frame is linearly ramped over 2^INTERP_SHIFT CEN ticks.
// Optional macro SIGMA_DELTA_DAC_MC_SECOND_ORDER_EN selects a second-order modulator (first order otherwise).
// Handshake: a frame transfers on any CLK edge where sample_valid & sample_ready; ready is low while a frame is pending or in RESET.
module sigma_delta_dac_mc #(
  parameter int WIDTH        = 16,
  parameter int CHANNELS     = 2,
  parameter int INTERP_SHIFT = 5
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         CEN,
  input  logic [CHANNELS*WIDTH-1:0]    sample_data,
  input  logic                         sample_valid,
  output logic                         sample_ready,
  output logic [CHANNELS-1:0]          DACout,
  output logic                         underrun,
  output logic                         state_dbg,
  output logic [CHANNELS*WIDTH-1:0]    cur_dbg
);

  localparam int FW = WIDTH + INTERP_SHIFT;
  localparam int CW = (INTERP_SHIFT > 0) ? INTERP_SHIFT : 1;
  localparam int DW = WIDTH + 1;
  localparam logic [WIDTH-1:0] MID     = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [FW-1:0]    CUR_RST = FW'(MID) << INTERP_SHIFT;

  typedef enum logic {S_HOLD = 1'b0, S_RAMP = 1'b1} state_t;

  state_t                    state_q, state_d;
  logic                      pending_q, pending_d;
  logic [CHANNELS*WIDTH-1:0] frame_q, frame_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [FW-1:0]             cur_q [CHANNELS];
  logic [FW-1:0]             cur_d [CHANNELS];
  logic signed [DW-1:0]      delta_q [CHANNELS];
  logic signed [DW-1:0]      delta_d [CHANNELS];
  logic [CHANNELS-1:0]       dac_q, dac_d;
  logic                      underrun_q, underrun_d;
  logic [WIDTH-1:0]          x_w [CHANNELS];
  logic                      accept;
  logic                      slot_end;
  logic                      load;

  assign sample_ready = ~pending_q & ~RESET;
  assign accept       = sample_valid & sample_ready;
  assign slot_end     = (INTERP_SHIFT == 0) || (cnt_q == '1);
  assign DACout       = dac_q;
  assign underrun     = underrun_q;
  assign state_dbg    = state_q;

`ifdef SIGMA_DELTA_DAC_MC_SECOND_ORDER_EN
  localparam int IW = WIDTH + 4;
  localparam logic signed [IW-1:0] HALF_S = IW'(MID);
  logic signed [IW-1:0] i1_q [CHANNELS];
  logic signed [IW-1:0] i1_d [CHANNELS];
  logic signed [IW-1:0] i2_q [CHANNELS];
  logic signed [IW-1:0] i2_d [CHANNELS];
  logic signed [IW-1:0] u_w [CHANNELS];
  logic signed [IW-1:0] fb_w [CHANNELS];
  logic signed [IW-1:0] i1n_w [CHANNELS];
  logic signed [IW-1:0] i2n_w [CHANNELS];
`else
  logic [WIDTH-1:0] acc_q [CHANNELS];
  logic [WIDTH-1:0] acc_d [CHANNELS];
  logic [WIDTH:0]   msum_w [CHANNELS];
`endif

  // The modulator always sees the registered interpolator value: one tick of pipeline.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    assign x_w[c] = cur_q[c][FW-1 -: WIDTH];
    assign cur_dbg[c*WIDTH +: WIDTH] = x_w[c];
`ifdef SIGMA_DELTA_DAC_MC_SECOND_ORDER_EN
    assign u_w[c]   = IW'($signed({1'b0, x_w[c]})) - HALF_S;
    assign fb_w[c]  = dac_q[c] ? HALF_S : -HALF_S;
    assign i1n_w[c] = i1_q[c] + u_w[c] - fb_w[c];
    assign i2n_w[c] = i2_q[c] + i1n_w[c] - fb_w[c];
`else
    assign msum_w[c] = {1'b0, acc_q[c]} + {1'b0, x_w[c]};
`endif
  end

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    frame_d    = frame_q;
    cnt_d      = cnt_q;
    cur_d      = cur_q;
    delta_d    = delta_q;
    underrun_d = 1'b0;
    load       = 1'b0;
    if (accept) begin
      pending_d = 1'b1;
      frame_d   = sample_data;
    end
    if (CEN) begin
      case (state_q)
        S_HOLD: begin
          if (pending_q) begin
            load    = 1'b1;
            state_d = S_RAMP;
            cnt_d   = '0;
          end
        end
        S_RAMP: begin
          for (int c = 0; c < CHANNELS; c++) begin
            cur_d[c] = cur_q[c] + FW'(delta_q[c]);
          end
          cnt_d = (INTERP_SHIFT == 0) ? '0 : cnt_q + CW'(1);
          // At a slot end cur_d is exactly the previous frame, so a pending frame chains without a gap.
          if (slot_end) begin
            if (pending_q) begin
              load = 1'b1;
            end else begin
              state_d    = S_HOLD;
              underrun_d = 1'b1;
            end
          end
        end
        default: state_d = S_HOLD;
      endcase
      if (load) begin
        pending_d = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
          delta_d[c] = $signed({1'b0, frame_q[c*WIDTH +: WIDTH]})
                     - $signed({1'b0, cur_d[c][FW-1 -: WIDTH]});
        end
      end
    end
  end

  always_comb begin
    dac_d = dac_q;
`ifdef SIGMA_DELTA_DAC_MC_SECOND_ORDER_EN
    i1_d = i1_q;
    i2_d = i2_q;
    if (CEN) begin
      for (int c = 0; c < CHANNELS; c++) begin
        i1_d[c]  = i1n_w[c];
        i2_d[c]  = i2n_w[c];
        dac_d[c] = ~i2n_w[c][IW-1];
      end
    end
`else
    acc_d = acc_q;
    if (CEN) begin
      for (int c = 0; c < CHANNELS; c++) begin
        acc_d[c] = msum_w[c][WIDTH-1:0];
        dac_d[c] = msum_w[c][WIDTH];
      end
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= S_HOLD;
      pending_q  <= 1'b0;
      frame_q    <= '0;
      cnt_q      <= '0;
      dac_q      <= '0;
      underrun_q <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        cur_q[c]   <= CUR_RST;
        delta_q[c] <= '0;
      end
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      frame_q    <= frame_d;
      cnt_q      <= cnt_d;
      dac_q      <= dac_d;
      underrun_q <= underrun_d;
      cur_q      <= cur_d;
      delta_q    <= delta_d;
    end
  end

`ifdef SIGMA_DELTA_DAC_MC_SECOND_ORDER_EN
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int c = 0; c < CHANNELS; c++) begin
        i1_q[c] <= '0;
        i2_q[c] <= '0;
      end
    end else begin
      i1_q <= i1_d;
      i2_q <= i2_d;
    end
  end
`else
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int c = 0; c < CHANNELS; c++) begin
        acc_q[c] <= MID;
      end
    end else begin
      acc_q <= acc_d;
    end
  end
`endif

endmodule
